// File: rtl/seg7_scan_display.sv
// Four-digit common-anode seven-segment scanner with frame-aligned double buffering.
// All pin outputs come from one register stage, so anodes cannot glitch between digits.
module seg7_scan_display #(
    parameter int DIV_WIDTH = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  AN,
    output logic        frame_done
);

    logic [DIV_WIDTH-1:0] div_cnt;
    logic [1:0]           idx;
    logic                 tick;
    logic                 boundary;

    logic                 pend;
    logic [15:0]          buf_value;
    logic [3:0]           buf_dp;
    logic [3:0]           buf_blank;

    logic [15:0]          disp_value;
    logic [3:0]           disp_dp;
    logic [3:0]           disp_blank;

    logic [3:0]           nibble;
    logic [6:0]           next_seg;
    logic                 next_dp;
    logic [3:0]           next_an;

    assign tick     = &div_cnt;
    assign boundary = tick && (idx == 2'd3);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= 2'd0;
        end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
            if (tick) begin
                idx <= idx + 2'd1;
            end
        end
    end

    // NOTE: buffer data is left unreset; pend alone decides whether it is ever used.
    always_ff @(posedge clk) begin
        if (load) begin
            buf_value <= value;
            buf_dp    <= dp_in;
            buf_blank <= blank;
        end
    end

    // A load on the boundary cycle is applied directly, so it never leaves pend set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
        end else if (boundary) begin
            pend <= 1'b0;
        end else if (load) begin
            pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_value <= 16'h0000;
            disp_dp    <= 4'b0000;
            disp_blank <= 4'b1111;
        end else if (boundary) begin
            if (load) begin
                disp_value <= value;
                disp_dp    <= dp_in;
                disp_blank <= blank;
            end else if (pend) begin
                disp_value <= buf_value;
                disp_dp    <= buf_dp;
                disp_blank <= buf_blank;
            end
        end
    end

    function automatic logic [6:0] hex_font(input logic [3:0] n);
        case (n)
            4'h0:    hex_font = 7'h40;
            4'h1:    hex_font = 7'h79;
            4'h2:    hex_font = 7'h24;
            4'h3:    hex_font = 7'h30;
            4'h4:    hex_font = 7'h19;
            4'h5:    hex_font = 7'h12;
            4'h6:    hex_font = 7'h02;
            4'h7:    hex_font = 7'h78;
            4'h8:    hex_font = 7'h00;
            4'h9:    hex_font = 7'h10;
            4'hA:    hex_font = 7'h08;
            4'hB:    hex_font = 7'h03;
            4'hC:    hex_font = 7'h46;
            4'hD:    hex_font = 7'h21;
            4'hE:    hex_font = 7'h06;
            default: hex_font = 7'h0E;
        endcase
    endfunction

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        nibble   = disp_value[{idx, 2'b00} +: 4];
        next_an  = 4'b1111;
        next_seg = 7'h7F;
        next_dp  = 1'b1;
        if (!disp_blank[idx]) begin
            next_an  = ~(4'b0001 << idx);
            next_seg = hex_font(nibble);
            next_dp  = ~disp_dp[idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            AN         <= 4'b1111;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            AN         <= next_an;
            seg        <= next_seg;
            dp         <= next_dp;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display at DIV_WIDTH=2 (4-cycle dwell, 16-cycle frame).
// Expected pin words are {AN, seg, dp}, hand-computed from the font table.
module tb_seg7_scan_display;

    localparam int DW = 2;
    localparam logic [11:0] DARK = 12'hFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  AN;
    logic        frame_done;

    int vectors     = 0;
    int miscompares = 0;
    int edge_cnt    = 0;

    always #5 clk = ~clk;

    seg7_scan_display #(.DIV_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank      (blank),
        .seg        (seg),
        .dp         (dp),
        .AN         (AN),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h (edge %0d)", tag, got, want, edge_cnt);
        end
    endtask

    task automatic drive(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        load  = ld;
        value = v;
        dp_in = d;
        blank = b;
    endtask

    task automatic drive_idle();
        drive(1'b0, 16'hFFFF, 4'hF, 4'h0);
    endtask

    // One rising edge, then sample on the falling edge; digit shown lags idx by one edge.
    task automatic step_check(input string tag, input logic [11:0] e0, input logic [11:0] e1,
                              input logic [11:0] e2, input logic [11:0] e3);
        logic [11:0] want;
        int d;
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        d = ((edge_cnt - 1) / 4) % 4;
        case (d)
            0:       want = e0;
            1:       want = e1;
            2:       want = e2;
            default: want = e3;
        endcase
        check({tag, "/pins"}, 32'({AN, seg, dp}), 32'(want));
        check({tag, "/frame_done"}, 32'(frame_done), 32'(edge_cnt % 16 == 0));
    endtask

    task automatic run(input string tag, input int stop, input logic [11:0] e0, input logic [11:0] e1,
                       input logic [11:0] e2, input logic [11:0] e3, input int ld_at,
                       input logic [15:0] ld_val, input logic [3:0] ld_dp, input logic [3:0] ld_blk);
        while (edge_cnt < stop) begin
            if (edge_cnt == ld_at) drive(1'b1, ld_val, ld_dp, ld_blk);
            else drive_idle();
            step_check(tag, e0, e1, e2, e3);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk);
        check("reset/pins", 32'({AN, seg, dp}), 32'(DARK));
        check("reset/frame_done", 32'(frame_done), 32'd0);
        check("reset/pend", 32'(dut.pend), 32'd0);
        rst = 1'b0;
        edge_cnt = 0;

        // Idle dark for 40 edges, then a mid-frame load that must wait for the boundary at edge 48.
        run("idle_load", 48, DARK, DARK, DARK, DARK, 40, 16'h3C07, 4'b0010, 4'b0000);
        run("show_3C07", 64, {4'b1110, 7'h78, 1'b1}, {4'b1101, 7'h40, 1'b0},
            {4'b1011, 7'h46, 1'b1}, {4'b0111, 7'h30, 1'b1}, -1, 16'h0, 4'h0, 4'h0);

        // Two loads in one frame: only the last must reach the display.
        while (edge_cnt < 80) begin
            if (edge_cnt == 66) drive(1'b1, 16'h1111, 4'h0, 4'h0);
            else if (edge_cnt == 70) drive(1'b1, 16'h0F0F, 4'h0, 4'h0);
            else drive_idle();
            step_check("two_loads", {4'b1110, 7'h78, 1'b1}, {4'b1101, 7'h40, 1'b0},
                       {4'b1011, 7'h46, 1'b1}, {4'b0111, 7'h30, 1'b1});
        end
        run("show_0F0F", 96, {4'b1110, 7'h0E, 1'b1}, {4'b1101, 7'h40, 1'b1},
            {4'b1011, 7'h0E, 1'b1}, {4'b0111, 7'h40, 1'b1}, -1, 16'h0, 4'h0, 4'h0);

        // Load coincident with the boundary tick (cycle after edge 111).
        run("bypass_load", 112, {4'b1110, 7'h0E, 1'b1}, {4'b1101, 7'h40, 1'b1},
            {4'b1011, 7'h0E, 1'b1}, {4'b0111, 7'h40, 1'b1}, 111, 16'hABCD, 4'h0, 4'h0);
        check("bypass/pend", 32'(dut.pend), 32'd0);
        run("show_ABCD", 128, {4'b1110, 7'h21, 1'b1}, {4'b1101, 7'h46, 1'b1},
            {4'b1011, 7'h03, 1'b1}, {4'b0111, 7'h08, 1'b1}, -1, 16'h0, 4'h0, 4'h0);

        // Blank digits 0 and 2; their decimal points must stay off too.
        run("load_blank", 144, {4'b1110, 7'h21, 1'b1}, {4'b1101, 7'h46, 1'b1},
            {4'b1011, 7'h03, 1'b1}, {4'b0111, 7'h08, 1'b1}, 130, 16'h8888, 4'hF, 4'b0101);
        run("show_blank", 160, DARK, {4'b1101, 7'h00, 1'b0}, DARK, {4'b0111, 7'h00, 1'b0},
            -1, 16'h0, 4'h0, 4'h0);
        run("load_5555", 176, DARK, {4'b1101, 7'h00, 1'b0}, DARK, {4'b0111, 7'h00, 1'b0},
            162, 16'h5555, 4'h0, 4'h0);

        // Pend 9999, then reset while digit 2 is on screen.
        run("pend_9999", 186, {4'b1110, 7'h12, 1'b1}, {4'b1101, 7'h12, 1'b1},
            {4'b1011, 7'h12, 1'b1}, {4'b0111, 7'h12, 1'b1}, 178, 16'h9999, 4'h0, 4'h0);
        rst = 1'b1;
        #1;
        check("mid_rst/pins", 32'({AN, seg, dp}), 32'(DARK));
        check("mid_rst/frame_done", 32'(frame_done), 32'd0);
        check("mid_rst/pend", 32'(dut.pend), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        edge_cnt = 0;

        // Discarded 9999 must never appear; a fresh load must land on restarted frame timing.
        run("post_rst", 32, DARK, DARK, DARK, DARK, 20, 16'h5AF1, 4'h0, 4'h0);
        run("show_5AF1", 48, {4'b1110, 7'h79, 1'b1}, {4'b1101, 7'h0E, 1'b1},
            {4'b1011, 7'h08, 1'b1}, {4'b0111, 7'h12, 1'b1}, -1, 16'h0, 4'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
